// File: rtl/led_display_bcm_driver.sv
// HUB75 scan engine: shifts one BCM bit plane per scan row, latches it, then lights it for
// BASE_LSB_CYCLES<<k cycles. Optional macro LED_DISPLAY_BRIGHTNESS_EN adds global dimming.
module led_display_bcm_driver #(
    parameter int unsigned NUM_COLS        = 64,
    parameter int unsigned NUM_ROWS        = 32,
    parameter int unsigned COLOUR_DEPTH    = 4,
    parameter int unsigned BASE_LSB_CYCLES = 32,
    parameter int unsigned RAM_ADDR_W      = 32,
    localparam int unsigned SCAN           = NUM_ROWS / 2,
    localparam int unsigned AW             = (SCAN > 1) ? $clog2(SCAN) : 1
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  enable_in,
`ifdef LED_DISPLAY_BRIGHTNESS_EN
    input  logic [7:0]            brightness_in,
`endif
    output logic [RAM_ADDR_W-1:0] ram_address_out,
    input  logic [31:0]           ram_rdata_in,
    output logic                  red_top_out,
    output logic                  green_top_out,
    output logic                  blue_top_out,
    output logic                  red_bot_out,
    output logic                  green_bot_out,
    output logic                  blue_bot_out,
    output logic                  bit_clk_out,
    output logic                  latch_out,
    output logic                  oe_n_out,
    output logic [AW-1:0]         addr_out,
    output logic                  frame_start_out
);

    localparam int unsigned D          = COLOUR_DEPTH;
    localparam int unsigned KW         = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned SHIFT_LAST = 2 * NUM_COLS + 1;
    localparam int unsigned DISP_MAX   = BASE_LSB_CYCLES << (D - 1);
    localparam int unsigned CNT_MAX    = (DISP_MAX > SHIFT_LAST) ? DISP_MAX : SHIFT_LAST;
    localparam int unsigned CW         = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StShift, StLatch, StDisplay} state_e;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [KW-1:0]   r_k;
    logic [AW-1:0]   r_row;
    logic            r_stop;

    logic [CW-1:0]   w_cnt_inc;
    logic [CW-1:0]   w_disp_len;
    logic [CW-1:0]   w_col_nxt;
    logic            w_disp_last;
    logic            w_shift_last;
    logic            w_last_k;
    logic            w_last_row;
    logic [KW-1:0]   w_k_nxt;
    logic [AW-1:0]   w_row_nxt;
    logic            w_stop;
    logic            w_on_first;
    logic            w_on_next;

    // Zero-extend so every channel slice is in range regardless of D.
    logic [6*D+31:0] w_rdata_ext;
    logic [D-1:0]    w_ch [6];
    logic            w_unused_rdata;

    assign w_rdata_ext    = {{(6*D){1'b0}}, ram_rdata_in};
    assign w_unused_rdata = ^w_rdata_ext[6*D+31:6*D];

    for (genvar g = 0; g < 6; g++) begin : g_ch
        assign w_ch[g] = w_rdata_ext[g*D +: D];
    end

    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_disp_len   = CW'(BASE_LSB_CYCLES) << r_k;
    assign w_col_nxt    = w_cnt_inc >> 1;
    assign w_disp_last  = (r_cnt == w_disp_len - 1'b1);
    assign w_shift_last = (r_cnt == CW'(SHIFT_LAST));
    assign w_last_k     = (r_k == KW'(D - 1));
    assign w_last_row   = (r_row == AW'(SCAN - 1));
    assign w_k_nxt      = w_last_k ? '0 : r_k + 1'b1;
    assign w_row_nxt    = !w_last_k ? r_row : (w_last_row ? '0 : r_row + 1'b1);
    assign w_stop       = r_stop || !enable_in;

`ifdef LED_DISPLAY_BRIGHTNESS_EN
    logic [CW+7:0] w_thresh;
    logic [CW+7:0] r_thresh;
    assign w_thresh   = ((CW+8)'(w_disp_len) * (CW+8)'(brightness_in)) >> 8;
    assign w_on_first = (w_thresh != '0);
    assign w_on_next  = ((CW+8)'(w_cnt_inc) < r_thresh);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_thresh <= '0;
        end else if (r_state == StLatch) begin
            r_thresh <= w_thresh;
        end
    end
`else
    assign w_on_first = 1'b1;
    assign w_on_next  = 1'b1;
`endif

    function automatic logic [RAM_ADDR_W-1:0] addr_of(input logic [AW-1:0] row,
                                                      input logic [CW-1:0] col);
        return RAM_ADDR_W'(row) * RAM_ADDR_W'(NUM_COLS) + RAM_ADDR_W'(col);
    endfunction

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state         <= StIdle;
            r_cnt           <= '0;
            r_k             <= '0;
            r_row           <= '0;
            r_stop          <= 1'b0;
            ram_address_out <= '0;
            red_top_out     <= 1'b0;
            green_top_out   <= 1'b0;
            blue_top_out    <= 1'b0;
            red_bot_out     <= 1'b0;
            green_bot_out   <= 1'b0;
            blue_bot_out    <= 1'b0;
            bit_clk_out     <= 1'b0;
            latch_out       <= 1'b0;
            oe_n_out        <= 1'b1;
            addr_out        <= '0;
            frame_start_out <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    oe_n_out        <= 1'b1;
                    bit_clk_out     <= 1'b0;
                    latch_out       <= 1'b0;
                    frame_start_out <= 1'b0;
                    r_stop          <= 1'b0;
                    if (enable_in) begin
                        r_state         <= StShift;
                        r_cnt           <= '0;
                        ram_address_out <= addr_of(r_row, '0);
                        frame_start_out <= (r_row == '0) && (r_k == '0);
                    end
                end
                StShift: begin
                    if (!enable_in) r_stop <= 1'b1;
                    frame_start_out <= 1'b0;
                    // Odd cycles carry RAM data for the address issued one cycle earlier.
                    if (r_cnt[0] && !w_shift_last) begin
                        red_top_out   <= w_ch[0][r_k];
                        green_top_out <= w_ch[1][r_k];
                        blue_top_out  <= w_ch[2][r_k];
                        red_bot_out   <= w_ch[3][r_k];
                        green_bot_out <= w_ch[4][r_k];
                        blue_bot_out  <= w_ch[5][r_k];
                    end
                    bit_clk_out <= !r_cnt[0] && (r_cnt >= CW'(2));
                    if (!w_cnt_inc[0] && (w_cnt_inc <= CW'(2 * NUM_COLS - 2))) begin
                        ram_address_out <= addr_of(r_row, w_col_nxt);
                    end
                    if (w_shift_last) begin
                        r_state   <= StLatch;
                        latch_out <= 1'b1;
                        addr_out  <= r_row;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StLatch: begin
                    if (!enable_in) r_stop <= 1'b1;
                    latch_out <= 1'b0;
                    r_state   <= StDisplay;
                    r_cnt     <= '0;
                    oe_n_out  <= !w_on_first;
                end
                default: begin
                    if (w_disp_last) begin
                        oe_n_out <= 1'b1;
                        r_k      <= w_k_nxt;
                        r_row    <= w_row_nxt;
                        r_stop   <= 1'b0;
                        if (w_stop) begin
                            r_state <= StIdle;
                        end else begin
                            r_state         <= StShift;
                            r_cnt           <= '0;
                            ram_address_out <= addr_of(w_row_nxt, '0);
                            frame_start_out <= (w_row_nxt == '0) && (w_k_nxt == '0);
                        end
                    end else begin
                        if (!enable_in) r_stop <= 1'b1;
                        r_cnt    <= w_cnt_inc;
                        oe_n_out <= !w_on_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_display_bcm_driver.sv
// Directed bench for led_display_bcm_driver on a 4x4 panel, 2-bit colour, 4-cycle LSB plane.
module tb_led_display_bcm_driver;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        enable_in;
    logic [31:0] ram_address_out;
    logic [31:0] ram_rdata_in;
    logic        red_top_out, green_top_out, blue_top_out;
    logic        red_bot_out, green_bot_out, blue_bot_out;
    logic        bit_clk_out, latch_out, oe_n_out, frame_start_out;
    logic [0:0]  addr_out;
`ifdef LED_DISPLAY_BRIGHTNESS_EN
    logic [7:0]  bright = 8'd128;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int fs_a, fs_b;

    logic [11:0] pix [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous frame RAM, one-cycle latency; upper bits are junk the DUT must ignore.
    always @(posedge clk) ram_rdata_in <= {20'hABCDE, pix[ram_address_out[2:0]]};

    led_display_bcm_driver #(
        .NUM_COLS(4), .NUM_ROWS(4), .COLOUR_DEPTH(2), .BASE_LSB_CYCLES(4), .RAM_ADDR_W(32)
    ) dut (
        .clk_in(clk),
        .reset_in(reset_in),
        .enable_in(enable_in),
`ifdef LED_DISPLAY_BRIGHTNESS_EN
        .brightness_in(bright),
`endif
        .ram_address_out(ram_address_out),
        .ram_rdata_in(ram_rdata_in),
        .red_top_out(red_top_out),
        .green_top_out(green_top_out),
        .blue_top_out(blue_top_out),
        .red_bot_out(red_bot_out),
        .green_bot_out(green_bot_out),
        .blue_bot_out(blue_bot_out),
        .bit_clk_out(bit_clk_out),
        .latch_out(latch_out),
        .oe_n_out(oe_n_out),
        .addr_out(addr_out),
        .frame_start_out(frame_start_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] rgb_now();
        return {red_top_out, green_top_out, blue_top_out,
                red_bot_out, green_bot_out, blue_bot_out};
    endfunction

    function automatic logic [5:0] exp_rgb(input logic [11:0] w, input int k);
        return {w[k], w[2+k], w[4+k], w[6+k], w[8+k], w[10+k]};
    endfunction

    function automatic int on_cycles(input int k);
`ifdef LED_DISPLAY_BRIGHTNESS_EN
        return ((4 << k) * 128) >> 8;
`else
        return 4 << k;
`endif
    endfunction

    // Entered while sampling SHIFT cycle 0; leaves one tick after the last DISPLAY cycle.
    task automatic run_plane(input int row, input int k, input int drop_at);
        for (int t = 0; t < 10; t++) begin
            if (t == drop_at) enable_in = 1'b0;
            chk("frame_start", 32'(frame_start_out), 32'((t == 0) && (row == 0) && (k == 0)));
            chk("oe_n_shift", 32'(oe_n_out), 32'd1);
            chk("bit_clk", 32'(bit_clk_out), 32'((t % 2 == 1) && (t >= 3)));
            chk("latch_shift", 32'(latch_out), 32'd0);
            if ((t % 2 == 0) && (t <= 6)) chk("ram_address", ram_address_out, 32'(row*4 + t/2));
            if (t >= 2) chk("rgb_shift", 32'(rgb_now()), 32'(exp_rgb(pix[row*4 + (t-2)/2], k)));
            tick();
        end
        chk("latch_pulse", 32'(latch_out), 32'd1);
        chk("addr_latch", 32'(addr_out), 32'(row));
        chk("oe_n_latch", 32'(oe_n_out), 32'd1);
        chk("bit_clk_latch", 32'(bit_clk_out), 32'd0);
        tick();
        for (int d = 0; d < (4 << k); d++) begin
            chk("oe_n_disp", 32'(oe_n_out), 32'((d < on_cycles(k)) ? 0 : 1));
            chk("latch_disp", 32'(latch_out), 32'd0);
            chk("bit_clk_disp", 32'(bit_clk_out), 32'd0);
            chk("rgb_hold", 32'(rgb_now()), 32'(exp_rgb(pix[row*4 + 3], k)));
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pix[0] = 12'h0C3; pix[1] = 12'h3F0; pix[2] = 12'hA5A; pix[3] = 12'h00F;
        pix[4] = 12'hFFF; pix[5] = 12'h000; pix[6] = 12'h5A5; pix[7] = 12'h924;
        reset_in  = 1'b1;
        enable_in = 1'b0;
        repeat (3) tick();
        chk("rst_rgb", 32'(rgb_now()), 32'd0);
        chk("rst_bit_clk", 32'(bit_clk_out), 32'd0);
        chk("rst_latch", 32'(latch_out), 32'd0);
        chk("rst_oe_n", 32'(oe_n_out), 32'd1);
        chk("rst_addr", 32'(addr_out), 32'd0);
        chk("rst_ram_address", ram_address_out, 32'd0);
        chk("rst_frame_start", 32'(frame_start_out), 32'd0);

        reset_in = 1'b0;
        tick();
        chk("idle_oe_n", 32'(oe_n_out), 32'd1);
        chk("idle_frame_start", 32'(frame_start_out), 32'd0);

        // Full frame: row0 k0, row0 k1, row1 k0, row1 k1, then back to row0 k0.
        enable_in = 1'b1;
        tick();
        fs_a = cyc;
        run_plane(0, 0, -1);
        run_plane(0, 1, -1);
        run_plane(1, 0, -1);
        run_plane(1, 1, -1);
        fs_b = cyc;
        chk("frame_period", 32'(fs_b - fs_a), 32'd68);

        // Drop enable mid-SHIFT: plane completes, then IDLE; re-enable resumes at plane 1.
        run_plane(0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            chk("stop_oe_n", 32'(oe_n_out), 32'd1);
            chk("stop_bit_clk", 32'(bit_clk_out), 32'd0);
            chk("stop_frame_start", 32'(frame_start_out), 32'd0);
            tick();
        end
        enable_in = 1'b1;
        tick();
        run_plane(0, 1, -1);

        // Reset in the middle of row 1 DISPLAY blanks at once and restarts at row 0.
        repeat (11) tick();
        chk("pre_reset_oe_n", 32'(oe_n_out), 32'(on_cycles(0) > 0 ? 0 : 1));
        reset_in = 1'b1;
        tick();
        chk("mid_reset_oe_n", 32'(oe_n_out), 32'd1);
        chk("mid_reset_latch", 32'(latch_out), 32'd0);
        chk("mid_reset_addr", 32'(addr_out), 32'd0);
        chk("mid_reset_ram_address", ram_address_out, 32'd0);
        reset_in = 1'b0;
        tick();
        run_plane(0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
